// File: rtl/btb_branch_target_if.sv
// Bus bundle between the pipeline and the branch-target unit.
//   flush            pipeline -> BTB  invalidate all entries (synchronous)
//   if_pc            pipeline -> BTB  fetch PC looked up this cycle
//   pred_hit/taken   BTB -> pipeline  combinational prediction for if_pc
//   pred_target      BTB -> pipeline  stored target (0 on miss)
//   ex_*             pipeline -> BTB  resolving conditional branch in EX
//   redirect(_pc)    BTB -> pipeline  registered mispredict redirect
// The master modport is the pipeline side; the slave modport is the BTB.
interface btb_branch_target_if #(
    parameter int XLEN = 32,
    parameter int OFFW = 16
);
    logic            flush;
    logic [XLEN-1:0] if_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_pc_4;
    logic [OFFW-1:0] ex_offset;
    logic            ex_taken;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output flush, if_pc, ex_valid, ex_pc, ex_pc_4, ex_offset,
               ex_taken, ex_pred_taken, ex_pred_target,
        input  pred_hit, pred_taken, pred_target, redirect, redirect_pc
    );

    modport slave (
        input  flush, if_pc, ex_valid, ex_pc, ex_pc_4, ex_offset,
               ex_taken, ex_pred_taken, ex_pred_target,
        output pred_hit, pred_taken, pred_target, redirect, redirect_pc
    );
endinterface

// File: rtl/btb_branch_target.sv
// Branch-target unit: direct-mapped BTB with 2-bit saturating counters.
// IF side looks up if_pc combinationally every cycle; EX side computes the
// PC-relative target (ex_pc_4 + sext(offset)<<2), updates the table and
// raises a registered one-cycle redirect when the carried prediction was wrong.
// Ports:
//   clk, rst_n (async, active-low)
//   bus : btb_branch_target_if.slave (flush, lookup, EX resolve, redirect)
//   stat_branches / stat_mispredicts : present only with BTB_STATS_EN defined;
//     saturating event counters, cleared by reset only (not by flush).
module btb_branch_target #(
    parameter int XLEN    = 32,
    parameter int OFFW    = 16,
    parameter int ENTRIES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    btb_branch_target_if.slave   bus
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    function automatic logic [1:0] ctr_sat(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        else
            return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    endfunction

    // Lookup (stage IF, combinational from table state, no write bypass)
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx          = bus.if_pc[IDX_W+1:2];
    assign if_tag          = bus.if_pc[XLEN-1:IDX_W+2];
    assign if_hit          = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign bus.pred_hit    = if_hit;
    assign bus.pred_taken  = if_hit && ctr_q[if_idx][1];
    assign bus.pred_target = if_hit ? target_q[if_idx] : '0;

    // Resolve (stage EX): target arithmetic and mispredict detection
    logic [IDX_W-1:0]       ex_idx;
    logic [TAG_W-1:0]       ex_tag;
    logic                   ex_hit;
    logic signed [XLEN-1:0] off_sext;
    logic [XLEN-1:0]        tgt;
    logic                   mispredict;
    logic                   unused_bits;

    assign ex_idx   = bus.ex_pc[IDX_W+1:2];
    assign ex_tag   = bus.ex_pc[XLEN-1:IDX_W+2];
    assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign off_sext = {{(XLEN-OFFW-2){bus.ex_offset[OFFW-1]}}, bus.ex_offset, 2'b00};
    // Wrap-around modulo 2^XLEN is intended; no overflow indication.
    assign tgt      = bus.ex_pc_4 + $unsigned(off_sext);
    assign mispredict = bus.ex_valid &&
                        ((bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && (bus.ex_pred_target != tgt)));
    assign unused_bits = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

    // Table update; flush beats a same-cycle update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b00;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++)
                valid_q[i] <= 1'b0;
        end else if (bus.ex_valid) begin
            if (ex_hit) begin
                ctr_q[ex_idx]    <= ctr_sat(ctr_q[ex_idx], bus.ex_taken);
                target_q[ex_idx] <= tgt;
            end else if (bus.ex_taken) begin
                // Allocate, replacing whatever aliases into this slot.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= tgt;
                ctr_q[ex_idx]    <= 2'b10;
            end
        end
    end

    // Redirect (stage EX -> p1), still produced on a flush cycle
    logic            redirect_p1;
    logic [XLEN-1:0] redirect_pc_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_p1    <= 1'b0;
            redirect_pc_p1 <= '0;
        end else begin
            redirect_p1 <= mispredict;
            if (mispredict)
                redirect_pc_p1 <= bus.ex_taken ? tgt : bus.ex_pc_4;
        end
    end

    assign bus.redirect    = redirect_p1;
    assign bus.redirect_pc = redirect_pc_p1;

`ifdef BTB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (bus.ex_valid)
                stat_branches <= sat_inc(stat_branches);
            if (mispredict)
                stat_mispredicts <= sat_inc(stat_mispredicts);
        end
    end
`endif
endmodule

// File: tb/tb_btb_branch_target.sv
// Self-checking bench for btb_branch_target: directed vector table for the
// named scenarios, an asynchronous reset during an active redirect, optional
// statistics counters, then randomized traffic against a slot-array model.
module tb_btb_branch_target;
    localparam int XLEN    = 32;
    localparam int OFFW    = 16;
    localparam int ENTRIES = 16;

    logic clk;
    logic rst_n;

    btb_branch_target_if #(.XLEN(XLEN), .OFFW(OFFW)) bus ();

`ifdef BTB_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    btb_branch_target #(.XLEN(XLEN), .OFFW(OFFW), .ENTRIES(ENTRIES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BTB_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [31:0] ifpc, input logic ev,
                         input logic [31:0] expc, input logic [15:0] off,
                         input logic tk, input logic ptk, input logic [31:0] ptgt);
        bus.flush          = fl;
        bus.if_pc          = ifpc;
        bus.ex_valid       = ev;
        bus.ex_pc          = expc;
        bus.ex_pc_4        = expc + 32'd4;
        bus.ex_offset      = off;
        bus.ex_taken       = tk;
        bus.ex_pred_taken  = ptk;
        bus.ex_pred_target = ptgt;
    endtask

    typedef struct {
        logic        fl;
        logic [31:0] if_pc;
        logic        ev;
        logic [31:0] ex_pc;
        logic [15:0] off;
        logic        tk;
        logic        ptk;
        logic [31:0] ptgt;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic        e_red;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vt [14];

    // Reference model: one slot per index remembering the whole word address
    // of the branch that owns it.
    bit          m_valid [ENTRIES];
    int unsigned m_wpc   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_rpc;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot_of(pc)] && (m_wpc[slot_of(pc)] == int'(pc >> 2));
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] off);
        logic signed [15:0] so;
        so = off;
        return pc4 + 32'(int'(so) * 4);
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h0040_0000;
            1:       base = 32'h0080_0000;
            default: base = 32'hFFFF_FF00;
        endcase
        return base + 32'(4 * $urandom_range(0, 31));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_wpc[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 0;
        end
        m_rpc = 0;
    endtask

    logic        r_fl, r_ev, r_tk, r_ptk, e_mis;
    logic [31:0] r_if, r_pc, r_ptgt, r_tgt;
    logic [15:0] r_off;
    int          s;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'h0040_0010, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0);

        //             fl  if_pc        ev  ex_pc        off      tk ptk ptgt          hit tk  tgt          red rpc
        vt[0]  = '{1'b0, 32'h0040_0010, 1'b1, 32'h0040_0010, 16'hFFFC, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0004};
        vt[1]  = '{1'b0, 32'h0040_0010, 1'b0, 32'h0,         16'h0,    1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0004, 1'b0, 32'h0040_0004};
        vt[2]  = '{1'b0, 32'h0040_0010, 1'b1, 32'h0040_0010, 16'hFFFC, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0004, 1'b0, 32'h0040_0004};
        vt[3]  = '{1'b0, 32'h0040_0010, 1'b1, 32'h0040_0010, 16'hFFFC, 1'b0, 1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h0040_0004, 1'b1, 32'h0040_0014};
        vt[4]  = '{1'b0, 32'h0040_0010, 1'b0, 32'h0,         16'h0,    1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0040_0004, 1'b0, 32'h0040_0014};
        vt[5]  = '{1'b0, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 16'h0002, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004};
        vt[6]  = '{1'b0, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 16'h0002, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0004};
        vt[7]  = '{1'b0, 32'h0080_0010, 1'b1, 32'h0080_0010, 16'h0008, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0080_0034};
        vt[8]  = '{1'b0, 32'h0040_0010, 1'b0, 32'h0,         16'h0,    1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0080_0034};
        vt[9]  = '{1'b0, 32'h0080_0010, 1'b0, 32'h0,         16'h0,    1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0080_0034, 1'b0, 32'h0080_0034};
        vt[10] = '{1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0040_0020, 16'h0001, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0040_0028};
        vt[11] = '{1'b0, 32'h0040_0020, 1'b0, 32'h0,         16'h0,    1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0040_0028};
        vt[12] = '{1'b0, 32'h0080_0010, 1'b0, 32'h0,         16'h0,    1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0040_0028};
        vt[13] = '{1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0,         16'h0,    1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0040_0028};

        // Reset state
        #1;
        chk("reset_pred_hit",    32'(bus.pred_hit),   32'h0);
        chk("reset_pred_taken",  32'(bus.pred_taken), 32'h0);
        chk("reset_pred_target", bus.pred_target,     32'h0);
        chk("reset_redirect",    32'(bus.redirect),   32'h0);
        chk("reset_redirect_pc", bus.redirect_pc,     32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int v = 0; v < 14; v++) begin
            drive(vt[v].fl, vt[v].if_pc, vt[v].ev, vt[v].ex_pc, vt[v].off,
                  vt[v].tk, vt[v].ptk, vt[v].ptgt);
            #1;
            chk($sformatf("vec%0d_pred_hit", v),    32'(bus.pred_hit),   32'(vt[v].e_hit));
            chk($sformatf("vec%0d_pred_taken", v),  32'(bus.pred_taken), 32'(vt[v].e_tk));
            chk($sformatf("vec%0d_pred_target", v), bus.pred_target,     vt[v].e_tgt);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_redirect", v),    32'(bus.redirect),   32'(vt[v].e_red));
            chk($sformatf("vec%0d_redirect_pc", v), bus.redirect_pc,     vt[v].e_rpc);
            @(negedge clk);
        end

        // Asynchronous reset while a redirect is being presented
        drive(1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040, 16'h0001, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("async_pre_redirect",    32'(bus.redirect), 32'h1);
        chk("async_pre_redirect_pc", bus.redirect_pc,   32'h0040_0048);
        chk("async_pre_pred_hit",    32'(bus.pred_hit), 32'h1);
        drive(1'b0, 32'h0040_0040, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_redirect",    32'(bus.redirect), 32'h0);
        chk("async_redirect_pc", bus.redirect_pc,   32'h0);
        chk("async_pred_hit",    32'(bus.pred_hit), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BTB_STATS_EN
        drive(1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100, 16'h0004, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100, 16'h0004, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100, 16'h0004, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0040_0100, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("stat_branches",    stat_branches,    32'd3);
        chk("stat_mispredicts", stat_mispredicts, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("stat_branches_reset",    stat_branches,    32'd0);
        chk("stat_mispredicts_reset", stat_mispredicts, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Randomized traffic against the model (table is empty after reset)
        m_reset();
        for (int n = 0; n < 400; n++) begin
            r_fl  = ($urandom_range(0, 31) == 0);
            r_if  = rand_pc();
            r_ev  = ($urandom_range(0, 3) != 0);
            r_pc  = rand_pc();
            r_off = 16'($urandom);
            r_tk  = 1'($urandom_range(0, 1));
            r_tgt = branch_target(r_pc + 32'd4, r_off);
            if (m_hit(r_pc) && $urandom_range(0, 1) == 1) begin
                r_ptk  = (m_ctr[slot_of(r_pc)] >= 2);
                r_ptgt = m_tgt[slot_of(r_pc)];
            end else begin
                r_ptk  = 1'($urandom_range(0, 1));
                r_ptgt = ($urandom_range(0, 1) == 1) ? r_tgt : $urandom;
            end
            drive(r_fl, r_if, r_ev, r_pc, r_off, r_tk, r_ptk, r_ptgt);
            #1;
            s = slot_of(r_if);
            chk("rnd_pred_hit",    32'(bus.pred_hit), 32'(m_hit(r_if)));
            chk("rnd_pred_taken",  32'(bus.pred_taken), 32'(m_hit(r_if) && m_ctr[s] >= 2));
            chk("rnd_pred_target", bus.pred_target, m_hit(r_if) ? m_tgt[s] : 32'h0);
            e_mis = r_ev && ((r_tk != r_ptk) || (r_tk && r_ptgt != r_tgt));
            if (e_mis)
                m_rpc = r_tk ? r_tgt : r_pc + 32'd4;
            @(posedge clk);
            #1;
            chk("rnd_redirect",    32'(bus.redirect), 32'(e_mis));
            chk("rnd_redirect_pc", bus.redirect_pc,   m_rpc);
            // Model update for this edge
            s = slot_of(r_pc);
            if (r_fl) begin
                for (int i = 0; i < ENTRIES; i++)
                    m_valid[i] = 0;
            end else if (r_ev) begin
                if (m_hit(r_pc)) begin
                    m_ctr[s] = r_tk ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                                    : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
                    m_tgt[s] = r_tgt;
                end else if (r_tk) begin
                    m_valid[s] = 1;
                    m_wpc[s]   = int'(r_pc >> 2);
                    m_tgt[s]   = r_tgt;
                    m_ctr[s]   = 2;
                end
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
